// File: rtl/uart_mmio_bridge_if.sv
// MEM-stage side of the memory-mapped UART port: write strobe/data, read data and status flags.
interface uart_mmio_bridge_if;
    logic       uart_write_ce;
    logic [7:0] uart_wdata;
    logic       clean_recv_flag;
    logic [7:0] uart_rdata;
    logic       recv_flag;
    logic       send_flag;
    logic       rx_frame_err;
    logic       rx_overrun;

    modport master (
        output uart_write_ce, uart_wdata, clean_recv_flag,
        input  uart_rdata, recv_flag, send_flag, rx_frame_err, rx_overrun
    );

    modport slave (
        input  uart_write_ce, uart_wdata, clean_recv_flag,
        output uart_rdata, recv_flag, send_flag, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_mmio_bridge.sv
// 8N1 UART behind the CPU's memory-mapped port: TX holding register + shifter, RX with
// 2-flop synchronizer, mid-bit sampling, frame-error and overrun pulses.
module uart_mmio_bridge #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic               clk,
    input  logic               rst,
    uart_mmio_bridge_if.slave  mmio,
    output logic               txd,
    input  logic               rxd
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    // ---------------- TX path ----------------
    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic [7:0]    hold_reg;
    logic          hold_full;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    // Write and hold->shift are mutually exclusive: one needs hold empty, the other full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= T_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else begin
            if (mmio.uart_write_ce && !hold_full) begin
                hold_reg  <= mmio.uart_wdata;
                hold_full <= 1'b1;
            end
            case (tx_state)
                T_IDLE: begin
                    if (hold_full) begin
                        tx_shift  <= hold_reg;
                        hold_full <= 1'b0;
                        tx_cnt    <= '0;
                        tx_state  <= T_START;
                    end
                end
                T_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= T_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        if (tx_bit == 3'd7) tx_state <= T_STOP;
                        else                tx_bit   <= tx_bit + 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (hold_full) begin
                            tx_shift  <= hold_reg;
                            hold_full <= 1'b0;
                            tx_state  <= T_START;
                        end else begin
                            tx_state <= T_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        txd = 1'b1;
        case (tx_state)
            T_START: txd = 1'b0;
            T_DATA:  txd = tx_shift[0];
            default: txd = 1'b1;
        endcase
    end

    // ---------------- RX path ----------------
    logic          rx_meta, rx_sync;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_armed;
    logic [7:0]    rdata;
    logic          recv_flag;
    logic          frame_err;
    logic          overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_state  <= R_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_armed  <= 1'b0;
            rdata     <= '0;
            recv_flag <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rxd;
            rx_sync   <= rx_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A commit later in this block overrides the clear (set wins).
            if (mmio.clean_recv_flag) recv_flag <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_sync) begin
                        rx_armed <= 1'b1;
                    end else if (rx_armed) begin
                        rx_armed <= 1'b0;
                        rx_cnt   <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= R_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= R_IDLE;
                        if (rx_sync) begin
                            rdata     <= rx_shift;
                            recv_flag <= 1'b1;
                            overrun   <= recv_flag && !mmio.clean_recv_flag;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign mmio.uart_rdata   = rdata;
    assign mmio.recv_flag    = recv_flag;
    assign mmio.send_flag    = !hold_full;
    assign mmio.rx_frame_err = frame_err;
    assign mmio.rx_overrun   = overrun;
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge at 8 clocks per bit: TX framing, gapless back-to-back,
// RX commit/clear/overrun, glitch and frame-error rejection, asynchronous reset mid-frame.
module tb_uart_mmio_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;
    logic rxd = 1'b1;

    uart_mmio_bridge_if mmio ();

    uart_mmio_bridge #(.CLK_FREQ(800), .BAUD(100)) dut (
        .clk  (clk),
        .rst  (rst),
        .mmio (mmio),
        .txd  (txd),
        .rxd  (rxd)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ovr_cnt  = 0;
    int fe_cnt   = 0;

    always @(negedge clk) begin
        if (mmio.rx_overrun)   ovr_cnt++;
        if (mmio.rx_frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        mmio.uart_write_ce = 1'b1;
        mmio.uart_wdata    = b;
        @(negedge clk);
        mmio.uart_write_ce = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then checks all 80 bit-time samples of the frame.
    task automatic tx_frame(input string tag, input logic [7:0] exp,
                            output bit found, output int waited);
        logic [9:0] pattern;
        logic [7:0] got;
        int errs;
        waited = 0;
        while (txd !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        found = (txd === 1'b0);
        if (found) begin
            pattern = {1'b1, exp, 1'b0};
            errs = 0;
            got  = '0;
            for (int j = 0; j < 80; j++) begin
                if (txd !== pattern[j/8]) errs++;
                if ((j % 8) == 4 && j >= 8 && j < 72) got[j/8-1] = txd;
                @(negedge clk);
            end
            check({tag, "_bits"}, errs, 0);
            check({tag, "_byte"}, {24'd0, got}, {24'd0, exp});
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int clean_at);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int j = 0; j < 80; j++) begin
            rxd = frame[j/8];
            mmio.clean_recv_flag = (j == clean_at);
            @(negedge clk);
        end
        rxd = 1'b1;
        mmio.clean_recv_flag = 1'b0;
    endtask

    bit found, found_a;
    int waited, waited_a;
    int base_ovr, base_fe;

    initial begin
        mmio.uart_write_ce   = 1'b0;
        mmio.uart_wdata      = '0;
        mmio.clean_recv_flag = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_txd",  txd, 1);
        check("rst_send", mmio.send_flag, 1);
        check("rst_recv", mmio.recv_flag, 0);
        check("rst_rdata", mmio.uart_rdata, 0);
        check("rst_pulse", {mmio.rx_overrun, mmio.rx_frame_err}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single frame 0xA5
        write_byte(8'hA5);
        check("t1_send_low", mmio.send_flag, 0);
        @(negedge clk);
        check("t1_send_back", mmio.send_flag, 1);
        tx_frame("t1", 8'hA5, found, waited);
        check("t1_found", found, 1);
        check("t1_latency", waited, 0);

        // 2: gapless back-to-back, third write dropped
        repeat (5) @(negedge clk);
        write_byte(8'h11);
        check("t2_send_low", mmio.send_flag, 0);
        @(negedge clk);
        fork
            tx_frame("t2a", 8'h11, found_a, waited_a);
            begin
                mmio.uart_write_ce = 1'b1;
                mmio.uart_wdata    = 8'h22;
                @(negedge clk);
                check("t2_hold_full", mmio.send_flag, 0);
                mmio.uart_wdata    = 8'h33;
                @(negedge clk);
                mmio.uart_write_ce = 1'b0;
            end
        join
        check("t2a_found", found_a, 1);
        tx_frame("t2b", 8'h22, found, waited);
        check("t2b_found", found, 1);
        check("t2b_gapless", waited, 0);
        tx_frame("t2c", 8'h33, found, waited);
        check("t2_dropped", found, 0);
        check("t2_send_idle", mmio.send_flag, 1);

        // 3: receive 0x3C, then clear over 3 cycles
        send_rx(8'h3C, 1'b1, -1);
        check("t3_recv", mmio.recv_flag, 1);
        check("t3_rdata", mmio.uart_rdata, 8'h3C);
        mmio.clean_recv_flag = 1'b1;
        repeat (3) @(negedge clk);
        mmio.clean_recv_flag = 1'b0;
        @(negedge clk);
        check("t3_cleared", mmio.recv_flag, 0);
        check("t3_rdata_kept", mmio.uart_rdata, 8'h3C);

        // 4: overrun, then clean coinciding with commit
        base_ovr = ovr_cnt;
        send_rx(8'h01, 1'b1, -1);
        check("t4_no_ovr_first", ovr_cnt - base_ovr, 0);
        send_rx(8'h02, 1'b1, -1);
        check("t4_ovr", ovr_cnt - base_ovr, 1);
        check("t4_rdata", mmio.uart_rdata, 8'h02);
        check("t4_recv", mmio.recv_flag, 1);
        send_rx(8'h03, 1'b1, 78);
        check("t4_set_wins", mmio.recv_flag, 1);
        check("t4_rdata2", mmio.uart_rdata, 8'h03);
        check("t4_no_ovr", ovr_cnt - base_ovr, 1);

        // 5: glitch rejection and frame error
        mmio.clean_recv_flag = 1'b1;
        @(negedge clk);
        mmio.clean_recv_flag = 1'b0;
        @(negedge clk);
        check("t5_cleared", mmio.recv_flag, 0);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("t5_glitch_recv", mmio.recv_flag, 0);
        check("t5_glitch_rdata", mmio.uart_rdata, 8'h03);
        base_fe = fe_cnt;
        send_rx(8'h55, 1'b0, -1);
        repeat (4) @(negedge clk);
        check("t5_frame_err", fe_cnt - base_fe, 1);
        check("t5_fe_recv", mmio.recv_flag, 0);
        check("t5_fe_rdata", mmio.uart_rdata, 8'h03);
        send_rx(8'h77, 1'b1, -1);
        check("t5_recover", mmio.uart_rdata, 8'h77);
        check("t5_recover_flag", mmio.recv_flag, 1);

        // 6: asynchronous reset mid-TX and mid-RX
        fork
            write_byte(8'h00);
            begin
                rxd = 1'b0;
                repeat (20) @(negedge clk);
            end
        join
        check("t6_mid_txd", txd, 0);
        #2 rst = 1'b1;
        rxd = 1'b1;
        #1;
        check("t6_txd", txd, 1);
        check("t6_send", mmio.send_flag, 1);
        check("t6_recv", mmio.recv_flag, 0);
        check("t6_rdata", mmio.uart_rdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        write_byte(8'hC3);
        tx_frame("t6_tx", 8'hC3, found, waited);
        check("t6_tx_found", found, 1);
        send_rx(8'h96, 1'b1, -1);
        check("t6_rx_rdata", mmio.uart_rdata, 8'h96);
        check("t6_rx_recv", mmio.recv_flag, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
